// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_fetch_unit_pkg;

    localparam int XLEN       = 32;
    localparam int INST_WIDTH = 32;

    localparam logic [XLEN-1:0]       RESET_PC_DEFAULT = 32'h8000_0000;
    localparam logic [INST_WIDTH-1:0] NOP_INST         = 32'h0000_0013;

    // Sequential fetch step; wraps naturally at 2^32.
    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

endpackage

// File: rtl/if_fetch_buf.sv
// Slot FIFO for the fetch stage: slots are allocated at request time and
// filled in order by memory responses; the head is handed to decode once filled.
module if_fetch_buf
    import if_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 4
)
(
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          clear,
    input  logic                          alloc,
    input  logic [XLEN-1:0]               alloc_pc,
    input  logic                          fill,
    input  logic [INST_WIDTH-1:0]         fill_inst,
    input  logic                          deq,
    output logic                          head_valid,
    output logic [XLEN-1:0]               head_pc,
    output logic [INST_WIDTH-1:0]         head_inst,
    output logic [$clog2(DEPTH):0]        occupancy,
    output logic [$clog2(DEPTH):0]        unfilled
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [XLEN-1:0]       pc_mem   [DEPTH];
    logic [INST_WIDTH-1:0] inst_mem [DEPTH];
    logic [DEPTH-1:0]      filled_reg;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [CW-1:0] head_ptr_reg;
    logic [CW-1:0] tail_ptr_reg;
    logic [CW-1:0] fill_ptr_reg;

    logic [AW-1:0] head_idx;
    logic [AW-1:0] tail_idx;
    logic [AW-1:0] fill_idx;

    logic alloc_ok;
    logic fill_ok;
    logic deq_ok;

    logic [DEPTH-1:0] alloc_hit;
    logic [DEPTH-1:0] fill_hit;
    logic [DEPTH-1:0] deq_hit;

    assign head_idx = head_ptr_reg[AW-1:0];
    assign tail_idx = tail_ptr_reg[AW-1:0];
    assign fill_idx = fill_ptr_reg[AW-1:0];

    assign occupancy = tail_ptr_reg - head_ptr_reg;
    assign unfilled  = tail_ptr_reg - fill_ptr_reg;

    assign head_valid = filled_reg[head_idx];
    assign head_pc    = pc_mem[head_idx];
    assign head_inst  = inst_mem[head_idx];

    assign alloc_ok = alloc && (occupancy != CW'(DEPTH));
    assign fill_ok  = fill && (unfilled != '0);
    assign deq_ok   = deq && head_valid;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot_sel
        assign alloc_hit[gi] = alloc_ok && (tail_idx == AW'(gi));
        assign fill_hit[gi]  = fill_ok  && (fill_idx == AW'(gi));
        assign deq_hit[gi]   = deq_ok   && (head_idx == AW'(gi));
    end

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            head_ptr_reg <= '0;
            tail_ptr_reg <= '0;
            fill_ptr_reg <= '0;
        end else begin
            if (alloc_ok) tail_ptr_reg <= tail_ptr_reg + CW'(1);
            if (fill_ok)  fill_ptr_reg <= fill_ptr_reg + CW'(1);
            if (deq_ok)   head_ptr_reg <= head_ptr_reg + CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            filled_reg <= '0;
        end else begin
            filled_reg <= (filled_reg & ~(alloc_hit | deq_hit)) | fill_hit;
        end
    end

    // Payload needs no reset: it is only observed behind a set filled bit.
    always_ff @(posedge clock) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (alloc_hit[i]) pc_mem[i]   <= alloc_pc;
            if (fill_hit[i])  inst_mem[i] <= fill_inst;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: issues sequential fetches, buffers responses and
// feeds decode through a valid/ready handshake; redirects squash the old path.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int              IBUF_DEPTH = 4
)
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  redirect_valid,
    input  logic [XLEN-1:0]       redirect_pc,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [XLEN-1:0]       imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [INST_WIDTH-1:0] imem_rsp_data,
    output logic                  if_valid,
    input  logic                  id_ready,
    output logic [XLEN-1:0]       pc_if,
    output logic [INST_WIDTH-1:0] inst_if
);

    localparam int CW = $clog2(IBUF_DEPTH) + 1;
    localparam int DW = $clog2(IBUF_DEPTH) + 2;

    logic            run_reg;
    logic [XLEN-1:0] fetch_pc_reg;
    logic            req_pending_reg;
    logic            pend_stale_reg;
    logic [XLEN-1:0] pend_addr_reg;
    logic [DW-1:0]   drop_cnt_reg;
    logic [DW-1:0]   drop_cnt_next;

    logic [CW-1:0]   occupancy;
    logic [CW-1:0]   unfilled;

    logic fire;
    logic stale_fire;
    logic rsp_drop;
    logic buf_alloc;
    logic buf_fill;
    logic buf_deq;

    // Request side depends on registered state only, so it can never glitch
    // with ready, id_ready or redirect in the same cycle.
    assign imem_req_valid = run_reg && (req_pending_reg || (occupancy < CW'(IBUF_DEPTH)));
    assign imem_req_addr  = req_pending_reg ? pend_addr_reg : fetch_pc_reg;

    assign fire       = imem_req_valid && imem_req_ready;
    assign stale_fire = fire && req_pending_reg && pend_stale_reg;
    assign rsp_drop   = imem_rsp_valid && (drop_cnt_reg != '0);

    assign buf_alloc = fire && !stale_fire && !redirect_valid;
    assign buf_fill  = imem_rsp_valid && !rsp_drop && !redirect_valid;
    assign buf_deq   = if_valid && id_ready && !redirect_valid;

    // On redirect every old-path request still owed by memory must be dropped:
    // those already counted, allocated-but-unfilled slots, and a request firing
    // now, minus any response consumed this very cycle.
    always_comb begin
        drop_cnt_next = drop_cnt_reg;
        if (redirect_valid) begin
            drop_cnt_next = drop_cnt_reg + DW'(unfilled) + DW'(fire) - DW'(imem_rsp_valid);
        end else begin
            drop_cnt_next = drop_cnt_reg + DW'(stale_fire) - DW'(rsp_drop);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            run_reg         <= 1'b0;
            fetch_pc_reg    <= RESET_PC;
            req_pending_reg <= 1'b0;
            pend_stale_reg  <= 1'b0;
            pend_addr_reg   <= '0;
            drop_cnt_reg    <= '0;
        end else begin
            run_reg         <= 1'b1;
            drop_cnt_reg    <= drop_cnt_next;
            req_pending_reg <= imem_req_valid && !imem_req_ready;
            if (imem_req_valid && !imem_req_ready) pend_addr_reg <= imem_req_addr;

            if (redirect_valid)  fetch_pc_reg <= redirect_pc;
            else if (buf_alloc)  fetch_pc_reg <= next_pc(fetch_pc_reg);

            // A request left hanging across a redirect belongs to the old path.
            if (fire)                                  pend_stale_reg <= 1'b0;
            else if (redirect_valid && imem_req_valid) pend_stale_reg <= 1'b1;
        end
    end

    if_fetch_buf #(
        .DEPTH (IBUF_DEPTH)
    ) u_buf (
        .clock      (clock),
        .reset      (reset),
        .clear      (redirect_valid),
        .alloc      (buf_alloc),
        .alloc_pc   (imem_req_addr),
        .fill       (buf_fill),
        .fill_inst  (imem_rsp_data),
        .deq        (buf_deq),
        .head_valid (if_valid),
        .head_pc    (pc_if),
        .head_inst  (inst_if),
        .occupancy  (occupancy),
        .unfilled   (unfilled)
    );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed and randomized bench for if_fetch_unit against a program-order
// reference model with an in-order latency memory.
module tb_if_fetch_unit;
    import if_fetch_unit_pkg::*;

    localparam logic [31:0] RPC = 32'h8000_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        if_valid;
    logic        id_ready = 1'b0;
    logic [31:0] pc_if;
    logic [31:0] inst_if;

    always #5 clock = ~clock;

    if_fetch_unit #(
        .RESET_PC   (RPC),
        .IBUF_DEPTH (4)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .id_ready       (id_ready),
        .pc_if          (pc_if),
        .inst_if        (inst_if)
    );

    typedef struct {
        int          due;
        logic [31:0] data;
    } rsp_t;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          lat = 1;
    int          last_due = 0;
    int          fires = 0;
    int          delivered = 0;
    rsp_t        memq[$];
    logic [31:0] exp_pc = RPC;
    logic [31:0] next_addr = RPC;
    logic [31:0] stale_addr = '0;
    bit          stale_flag = 1'b0;
    bit          prev_hold = 1'b0;
    logic [31:0] prev_addr = '0;

    // Memory contents: a fixed scramble of the address.
    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, update the model, advance.
    task automatic step(input bit rst, input bit rdy, input bit idr, input bit redir,
                        input logic [31:0] rpc);
        bit   fire;
        bit   deliver;
        rsp_t r;
        reset          = rst;
        imem_req_ready = rdy;
        id_ready       = idr;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (!rst && memq.size() > 0 && memq[0].due == cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memq[0].data;
            void'(memq.pop_front());
        end
        if (prev_hold) begin
            check("req_hold_valid", 32'(imem_req_valid), 32'd1);
            check("req_hold_addr", imem_req_addr, prev_addr);
        end
        prev_hold = !rst && imem_req_valid && !rdy;
        prev_addr = imem_req_addr;
        if (rst) begin
            memq.delete();
            last_due   = cyc;
            exp_pc     = RPC;
            next_addr  = RPC;
            stale_flag = 1'b0;
        end else begin
            fire = imem_req_valid && rdy;
            if (fire) begin
                fires++;
                if (stale_flag) begin
                    check("fire_addr_stale", imem_req_addr, stale_addr);
                    stale_flag = 1'b0;
                end else begin
                    check("fire_addr", imem_req_addr, next_addr);
                    next_addr += 32'd4;
                end
                last_due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
                r.due  = last_due;
                r.data = inst_of(imem_req_addr);
                memq.push_back(r);
            end
            deliver = if_valid && idr && !redir;
            if (deliver) begin
                check("pc_if", pc_if, exp_pc);
                check("inst_if", inst_if, inst_of(exp_pc));
                exp_pc += 32'd4;
                delivered++;
            end
            if (redir) begin
                if (imem_req_valid && !rdy) begin
                    stale_flag = 1'b1;
                    stale_addr = imem_req_addr;
                end
                next_addr = rpc;
                exp_pc    = rpc;
            end
        end
        @(posedge clock);
        @(negedge clock);
        cyc++;
    endtask

    task automatic do_reset();
        step(1, 1, 0, 0, '0);
        step(1, 1, 0, 0, '0);
        check("reset_if_valid", 32'(if_valid), 32'd0);
        check("reset_req_valid", 32'(imem_req_valid), 32'd0);
    endtask

    task automatic wait_valid(input logic [31:0] pc, input string tag);
        int n = 0;
        while (!if_valid && n < 30) begin
            step(0, 1, 0, 0, '0);
            n++;
        end
        check({tag, "_valid"}, 32'(if_valid), 32'd1);
        check({tag, "_pc"}, pc_if, pc);
        check({tag, "_inst"}, inst_if, inst_of(pc));
    endtask

    initial begin
        int f0;
        int d0;
        @(negedge clock);

        // Streaming at one instruction per cycle with 1-cycle memory.
        lat = 1;
        do_reset();
        for (int k = 0; k < 20; k++) begin
            if (k == 2)  check("stream_first_gap", 32'(if_valid), 32'd0);
            if (k >= 3)  check("stream_no_gap", 32'(if_valid), 32'd1);
            step(0, 1, 1, 0, '0);
        end

        // Decode stalled: exactly IBUF_DEPTH requests, head held.
        do_reset();
        f0 = fires;
        for (int k = 0; k < 12; k++) begin
            if (k >= 4) check("stall_pc_hold", pc_if, RPC);
            step(0, 1, 0, 0, '0);
        end
        check("stall_fire_count", 32'(fires - f0), 32'd4);
        check("stall_req_valid", 32'(imem_req_valid), 32'd0);
        check("stall_if_valid", 32'(if_valid), 32'd1);
        d0 = delivered;
        for (int k = 0; k < 20; k++) step(0, 1, 1, 0, '0);
        check("stall_resume_count", 32'(delivered - d0 >= 15), 32'd1);

        // Memory not ready: address held.
        do_reset();
        for (int k = 0; k < 3; k++) step(0, 1, 1, 0, '0);
        for (int k = 0; k < 3; k++) begin
            check("noready_addr", imem_req_addr, 32'h8000_0008);
            step(0, 0, 1, 0, '0);
        end
        check("noready_valid", 32'(imem_req_valid), 32'd1);
        step(0, 1, 1, 0, '0);
        check("noready_next_addr", imem_req_addr, 32'h8000_000C);

        // 3-cycle latency, redirect with requests outstanding.
        lat = 3;
        do_reset();
        for (int k = 0; k < 3; k++) step(0, 1, 1, 0, '0);
        step(0, 1, 1, 1, 32'h8000_0100);
        wait_valid(32'h8000_0100, "redir_lat3");
        for (int k = 0; k < 10; k++) step(0, 1, 1, 0, '0);

        // Redirect coinciding with a response and a request fire.
        lat = 1;
        do_reset();
        for (int k = 0; k < 6; k++) step(0, 1, 1, 0, '0);
        check("redir_same_rsp", 32'(imem_rsp_valid | (memq.size() > 0)), 32'd1);
        step(0, 1, 1, 1, 32'h8000_0200);
        wait_valid(32'h8000_0200, "redir_same");
        check("redir_drop_zero", 32'(dut.drop_cnt_reg), 32'd0);

        // Reset in the middle of a stream with buffered instructions.
        do_reset();
        for (int k = 0; k < 5; k++) step(0, 1, 0, 0, '0);
        step(1, 1, 0, 0, '0);
        check("midreset_if_valid", 32'(if_valid), 32'd0);
        check("midreset_req_valid", 32'(imem_req_valid), 32'd0);
        step(0, 1, 0, 0, '0);
        wait_valid(RPC, "midreset_restart");

        // Random handshakes and redirects at several latencies.
        for (int l = 1; l <= 3; l++) begin
            lat = l;
            do_reset();
            for (int k = 0; k < 400; k++) begin
                step(0, ($urandom_range(3) != 0), ($urandom_range(9) < 7),
                     ($urandom_range(19) == 0),
                     32'h8000_0000 | ({$urandom} & 32'h0000_FFFC));
            end
            for (int k = 0; k < 10; k++) step(0, 1, 0, 0, '0);
            wait_valid(exp_pc, "rand_drain");
            d0 = delivered;
            for (int k = 0; k < 30; k++) step(0, 1, 1, 0, '0);
            check("rand_progress", 32'(delivered - d0 >= 5), 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch (IF) stage: the producer end of the IF->ID valid/ready handshake.
- Generates sequential PCs and issues in-order requests to the instruction memory port.
- Buffers returned instructions and presents {pc_if, inst_if} with if_valid to the ID segment register, which accepts on id_ready.
- Handles redirects from EX/WB by discarding in-flight and buffered wrong-path fetches.

Parameters:
- RESET_PC, 32'h8000_0000, first fetch address after reset.
- IBUF_DEPTH, 4, fetch slots (outstanding + buffered); power of two, >=2; 4 sustains 1 inst/cycle at 1-cycle memory latency.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- redirect_valid  in  1  flush wrong path, restart at redirect_pc
- redirect_pc  in  32  redirect target, word aligned
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  fetch address
- imem_rsp_valid  in  1  response valid (in order, latency >=1, no backpressure)
- imem_rsp_data  in  32  fetched instruction
- if_valid  out  1  {pc_if, inst_if} valid to ID
- id_ready  in  1  ID segment register accepts this cycle
- pc_if  out  32  PC of head instruction
- inst_if  out  32  head instruction

Behaviour:
- Clock is clock; reset is synchronous, active-high, on clock rising edge.
- Reset: fetch_pc=RESET_PC, slots empty, occupancy=0, drop_cnt=0, req_pending=0, if_valid=0, imem_req_valid=0. pc_if/inst_if are don't-care while if_valid=0.
- Slot FIFO of IBUF_DEPTH entries {pc, inst, filled}. A slot is allocated on request fire (imem_req_valid && imem_req_ready).
- Request issue: imem_req_valid=1 when occupancy<IBUF_DEPTH, or when req_pending. It is driven from registered state only: no combinational path from imem_req_ready, id_ready or redirect_valid.
- Once asserted, imem_req_valid and imem_req_addr hold stable until fire. Redirect never retracts a pending request.
- On fire: imem_req_addr=fetch_pc, fetch_pc+=4 (wraps mod 2^32).
- Response: in order. If drop_cnt>0: decrement and discard. Else write inst into the oldest unfilled slot and set filled.
- Output: if_valid = head slot filled. pc_if/inst_if come from the head slot; registered, no bypass of imem_rsp_data. Dequeue on if_valid && id_ready; head advances.
- Simultaneous fire + dequeue: occupancy unchanged. Full FIFO with id_ready=0: stall issue, hold outputs stable.
- Redirect (redirect_valid=1) at the clock edge:
  - fetch_pc=redirect_pc, all slots cleared, occupancy=0, if_valid=0 next cycle.
  - drop_cnt += outstanding (allocated, unfilled) requests, including one firing this cycle.
  - A response arriving this same cycle is discarded (old path); count it accordingly.
  - A non-fired pending request remains asserted with its old address and is added to drop_cnt when it fires.
  - Redirect has priority over dequeue; a concurrent id_ready handshake is ignored.
- Redirect wins over same-cycle fill, fire bookkeeping and dequeue. Back-to-back redirects accumulate drop_cnt correctly.
- drop_cnt width: clog2(IBUF_DEPTH)+2 bits. It never exceeds IBUF_DEPTH+1.
- Latency: at memory latency L, first if_valid appears L+1 cycles after fire.
- Reset mid-operation clears all state. In-flight responses after reset are the memory's responsibility; memory must also be reset.

Decomposition:
- Shared package: RESET_PC default, INST_WIDTH=32, XLEN=32, NOP encoding 32'h0000_0013.
- One sub-module: if_fetch_buf, a slot FIFO with allocate/fill/dequeue/clear ports and occupancy output.
- Top holds fetch_pc, req_pending, drop_cnt and the handshake logic.

Test Plan:
- Reset release, memory ready, 1-cycle latency, id_ready=1 -> requests 0x8000_0000, _0004, _0008...; if_valid from cycle 3 with consecutive PCs, one per cycle, no gaps.
- id_ready=0 for 10 cycles -> exactly 4 requests issued, then imem_req_valid=0; pc_if=0x8000_0000 held stable; on id_ready=1, PCs continue in order, none lost or duplicated.
- imem_req_ready=0 for 3 cycles with valid high -> addr held at 0x8000_0008, no PC advance; fires on ready.
- 3-cycle latency with 2 outstanding, redirect to 0x8000_0100 -> both old responses discarded, next if_valid shows pc_if=0x8000_0100 with its instruction.
- Redirect in the same cycle as a response and a request fire -> both old instructions dropped; drop_cnt returns to 0; first delivered pc=redirect_pc.
- Reset asserted mid-stream with 3 buffered -> next cycle if_valid=0, imem_req_valid=0; after release, fetch restarts at 0x8000_0000.
